// File: rtl/i2c_master_sched.sv
// Two-requester round-robin I2C master: runs one register write or read transaction
// at a time, generating SCL and an open-drain SDA from a quarter-period divider.
module i2c_master_sched #(
   parameter int CLK_DIV = 25
) (
   input  logic        Clk_In,
   input  logic        Reset_In,
   input  logic [1:0]  Req_Valid_In,
   input  logic [13:0] Req_Dev_Addr_In,
   input  logic [1:0]  Req_Rw_In,
   input  logic [15:0] Req_Reg_Addr_In,
   input  logic [15:0] Req_Wdata_In,
   output logic [1:0]  Req_Grant_Out,
   output logic [1:0]  Done_Out,
   output logic [7:0]  Rdata_Out,
   output logic        Nack_Out,
   output logic        Busy_Out,
   output logic        I2C_SCL,
   inout  wire         I2C_SDA
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_MNACK, S_STOP
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [DW-1:0] r_div;
   logic [1:0]    r_q;
   logic [3:0]    r_bit;
   logic [7:0]    r_shift, r_rx, r_reg, r_wdata, r_rdata;
   logic [6:0]    r_dev;
   logic [1:0]    r_grant, r_done;
   logic          r_rw, r_owner, r_last, r_ack_smp, r_nack_flag, r_nack;
   logic          r_busy, r_scl, r_sda_low;
   logic          w_tick, w_bit_end, w_sda_in, w_pick, w_can_grant, w_scl, w_sda_low;

   assign w_sda_in    = I2C_SDA;
   assign w_tick      = (r_div == DIV_MAX);
   assign w_bit_end   = w_tick && (r_q == 2'd3);
   assign w_can_grant = (r_state == S_IDLE) && (r_grant == 2'b00) && (Req_Valid_In != 2'b00);
   // On a tie the requester not granted last wins.
   assign w_pick      = (Req_Valid_In == 2'b11) ? ~r_last : Req_Valid_In[1];

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (r_grant != 2'b00) w_state_nxt = S_START;
         S_START:     if (w_bit_end) w_state_nxt = S_ADDR;
         S_ADDR:      if (w_bit_end && (r_bit == 4'd0)) w_state_nxt = S_ADDR_ACK;
         S_ADDR_ACK:  if (w_bit_end) w_state_nxt = r_ack_smp ? S_STOP : (r_rw ? S_RDATA : S_REG);
         S_REG:       if (w_bit_end && (r_bit == 4'd0)) w_state_nxt = S_REG_ACK;
         S_REG_ACK:   if (w_bit_end) w_state_nxt = r_ack_smp ? S_STOP : S_WDATA;
         S_WDATA:     if (w_bit_end && (r_bit == 4'd0)) w_state_nxt = S_WDATA_ACK;
         S_WDATA_ACK: if (w_bit_end) w_state_nxt = S_STOP;
         S_RDATA:     if (w_bit_end && (r_bit == 4'd0)) w_state_nxt = S_MNACK;
         S_MNACK:     if (w_bit_end) w_state_nxt = S_STOP;
         S_STOP:      if (w_bit_end) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_scl     = 1'b1;
      w_sda_low = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_scl     = 1'b1;
            w_sda_low = 1'b0;
         end
         S_START: begin
            w_scl     = (r_q != 2'd3);
            w_sda_low = r_q[1];
         end
         S_ADDR, S_REG, S_WDATA: begin
            w_scl     = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda_low = ~r_shift[7];
         end
         S_STOP: begin
            w_scl     = (r_q != 2'd0);
            w_sda_low = ~r_q[1];
         end
         default: begin
            // ACK, read-data and master-NACK bits all leave SDA released
            w_scl     = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda_low = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_div <= '0;             r_q <= 2'd0;          r_bit <= 4'd7;
         r_shift <= 8'h00;        r_rx <= 8'h00;        r_reg <= 8'h00;
         r_wdata <= 8'h00;        r_rdata <= 8'h00;     r_dev <= 7'h00;
         r_grant <= 2'b00;        r_done <= 2'b00;      r_rw <= 1'b0;
         r_owner <= 1'b0;         r_last <= 1'b1;       r_ack_smp <= 1'b0;
         r_nack_flag <= 1'b0;     r_nack <= 1'b0;       r_busy <= 1'b0;
         r_scl <= 1'b1;           r_sda_low <= 1'b0;
      end else begin
         r_grant   <= 2'b00;
         r_done    <= 2'b00;
         r_scl     <= w_scl;
         r_sda_low <= w_sda_low;
         if (w_can_grant) begin
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_last  <= w_pick;
            r_owner <= w_pick;
            r_dev   <= w_pick ? Req_Dev_Addr_In[13:7] : Req_Dev_Addr_In[6:0];
            r_rw    <= Req_Rw_In[w_pick];
            r_reg   <= w_pick ? Req_Reg_Addr_In[15:8] : Req_Reg_Addr_In[7:0];
            r_wdata <= w_pick ? Req_Wdata_In[15:8] : Req_Wdata_In[7:0];
         end
         if (r_grant != 2'b00) begin
            r_busy      <= 1'b1;
            r_div       <= '0;
            r_q         <= 2'd0;
            r_bit       <= 4'd7;
            r_shift     <= {r_dev, r_rw};
            r_nack_flag <= 1'b0;
         end else if (r_state != S_IDLE) begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) r_q <= r_q + 2'd1;
            if ((r_q == 2'd2) && (r_div == '0)) begin
               r_ack_smp <= w_sda_in;
               if (r_state == S_RDATA) r_rx <= {r_rx[6:0], w_sda_in};
            end
            if (w_bit_end) begin
               case (r_state)
                  S_ADDR, S_REG, S_WDATA, S_RDATA: begin
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_bit   <= r_bit - 4'd1;
                  end
                  S_ADDR_ACK: begin
                     r_shift     <= r_reg;
                     r_bit       <= 4'd7;
                     r_nack_flag <= r_ack_smp;
                  end
                  S_REG_ACK: begin
                     r_shift     <= r_wdata;
                     r_bit       <= 4'd7;
                     r_nack_flag <= r_ack_smp;
                  end
                  S_WDATA_ACK: r_nack_flag <= r_ack_smp;
                  S_STOP: begin
                     r_busy  <= 1'b0;
                     r_done  <= r_owner ? 2'b10 : 2'b01;
                     r_nack  <= r_nack_flag;
                     r_rdata <= (r_rw && !r_nack_flag) ? r_rx : 8'h00;
                  end
                  default: r_bit <= r_bit;
               endcase
            end
         end
      end
   end

   assign Req_Grant_Out = r_grant;
   assign Done_Out      = r_done;
   assign Rdata_Out     = r_rdata;
   assign Nack_Out      = r_nack;
   assign Busy_Out      = r_busy;
   assign I2C_SCL       = r_scl;
   assign I2C_SDA       = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_sched.sv
// Bench for i2c_master_sched: table of single-requester transactions against an I2C
// slave model, plus arbitration and mid-transaction reset sequences and a bus monitor.
module tb_i2c_master_sched;
   localparam int CLK_DIV = 4;
   localparam int BIT_T   = 4 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  Req_Valid_In;
   logic [13:0] Req_Dev_Addr_In;
   logic [1:0]  Req_Rw_In;
   logic [15:0] Req_Reg_Addr_In;
   logic [15:0] Req_Wdata_In;
   logic [1:0]  Req_Grant_Out, Done_Out;
   logic [7:0]  Rdata_Out;
   logic        Nack_Out, Busy_Out, I2C_SCL;
   wire         w_sda;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2c_master_sched #(.CLK_DIV(CLK_DIV)) dut (
      .Clk_In(clk), .Reset_In(rst), .Req_Valid_In(Req_Valid_In),
      .Req_Dev_Addr_In(Req_Dev_Addr_In), .Req_Rw_In(Req_Rw_In),
      .Req_Reg_Addr_In(Req_Reg_Addr_In), .Req_Wdata_In(Req_Wdata_In),
      .Req_Grant_Out(Req_Grant_Out), .Done_Out(Done_Out), .Rdata_Out(Rdata_Out),
      .Nack_Out(Nack_Out), .Busy_Out(Busy_Out), .I2C_SCL(I2C_SCL), .I2C_SDA(w_sda)
   );

   // Slave model at address 0x68
   localparam int SL_IDLE = 0, SL_ADDR = 1, SL_REG = 2, SL_WD = 3, SL_ACK = 4, SL_TX = 5, SL_MACK = 6;
   int         s_st = SL_IDLE, s_next = SL_IDLE, s_cnt = 0;
   logic [7:0] s_sh, s_txsh, s_got_reg, s_got_data;
   logic       s_oe = 1'b0, s_mnack, scl_p = 1'b1, sda_p = 1'b1;
   logic [7:0] s_tx_data;
   int         s_nack_at;

   assign w_sda = s_oe ? 1'b0 : 1'bz;
   pullup (w_sda);

   always @(posedge clk) begin
      scl_p <= I2C_SCL;
      sda_p <= w_sda;
      if (rst) begin
         s_st <= SL_IDLE;
         s_oe <= 1'b0;
      end else if (I2C_SCL && scl_p && sda_p && !w_sda) begin
         s_st <= SL_ADDR; s_cnt <= 0; s_oe <= 1'b0;
      end else if (I2C_SCL && scl_p && !sda_p && w_sda) begin
         s_st <= SL_IDLE; s_oe <= 1'b0;
      end else if (I2C_SCL && !scl_p) begin
         case (s_st)
            SL_ADDR, SL_REG, SL_WD: begin s_sh <= {s_sh[6:0], w_sda}; s_cnt <= s_cnt + 1; end
            SL_MACK: begin s_mnack <= w_sda; s_st <= SL_IDLE; end
            default: ;
         endcase
      end else if (!I2C_SCL && scl_p) begin
         case (s_st)
            SL_ADDR: if (s_cnt == 8) begin
               if (s_sh[7:1] == 7'h68) begin
                  s_oe <= 1'b1; s_next <= s_sh[0] ? SL_TX : SL_REG; s_st <= SL_ACK;
               end else s_st <= SL_IDLE;
            end
            SL_REG: if (s_cnt == 8) begin
               s_got_reg <= s_sh;
               if (s_nack_at == 1) s_st <= SL_IDLE;
               else begin s_oe <= 1'b1; s_next <= SL_WD; s_st <= SL_ACK; end
            end
            SL_WD: if (s_cnt == 8) begin
               s_got_data <= s_sh;
               if (s_nack_at == 2) s_st <= SL_IDLE;
               else begin s_oe <= 1'b1; s_next <= SL_IDLE; s_st <= SL_ACK; end
            end
            SL_ACK: begin
               s_cnt <= 0;
               if (s_next == SL_TX) begin
                  s_oe <= ~s_tx_data[7]; s_txsh <= {s_tx_data[6:0], 1'b0}; s_cnt <= 1;
               end else s_oe <= 1'b0;
               s_st <= s_next;
            end
            SL_TX: if (s_cnt == 8) begin
               s_oe <= 1'b0; s_st <= SL_MACK;
            end else begin
               s_oe <= ~s_txsh[7]; s_txsh <= {s_txsh[6:0], 1'b0}; s_cnt <= s_cnt + 1;
            end
            default: ;
         endcase
      end
   end

   // Bus monitor: START/STOP counts, SCL phase lengths, grant only when not busy
   logic mon_en = 1'b0;
   int   n_start = 0, n_stop = 0, mon_viol = 0, m_last = 0;
   logic m_scl_p = 1'b1, m_sda_p = 1'b1, m_hi_sda = 1'b1;

   always @(posedge clk) begin
      int len;
      len = cyc - m_last;
      m_scl_p <= I2C_SCL;
      m_sda_p <= w_sda;
      if (I2C_SCL && m_scl_p && (w_sda !== m_sda_p)) begin
         m_hi_sda <= 1'b1;
         if (mon_en && !rst) begin
            if (w_sda) n_stop <= n_stop + 1;
            else       n_start <= n_start + 1;
         end
      end
      if (I2C_SCL !== m_scl_p) begin
         m_last   <= cyc;
         m_hi_sda <= 1'b0;
         if (mon_en && !rst && !(m_scl_p && m_hi_sda) && (len != 2 * CLK_DIV)) begin
            mon_viol <= mon_viol + 1;
            if (mon_viol < 5)
               $display("FAIL scl_phase: level %0b lasted %0d cycles, required %0d", m_scl_p, len, 2 * CLK_DIV);
         end
      end
      if (mon_en && (Req_Grant_Out != 2'b00) && (Busy_Out || (Req_Grant_Out == 2'b11))) begin
         mon_viol <= mon_viol + 1;
         $display("FAIL grant_idle: grant %b while busy %b, required a one-hot grant only when idle",
                  Req_Grant_Out, Busy_Out);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         ri;
      logic [6:0] dev;
      logic       rw;
      logic [7:0] rad;
      logic [7:0] wdata;
      logic [7:0] sdata;
      int         nack_at;
      int         lat;
      logic [7:0] rdata;
      logic       nack;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      int   g, st0, sp0;
      logic [1:0] eg;
      bit   got;
      eg  = (v.ri == 1) ? 2'b10 : 2'b01;
      st0 = n_start;
      sp0 = n_stop;
      s_tx_data = v.sdata;
      s_nack_at = v.nack_at;
      Req_Dev_Addr_In[7*v.ri +: 7] = v.dev;
      Req_Rw_In[v.ri]              = v.rw;
      Req_Reg_Addr_In[8*v.ri +: 8] = v.rad;
      Req_Wdata_In[8*v.ri +: 8]    = v.wdata;
      Req_Valid_In                 = eg;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         step();
         if (Req_Grant_Out != 2'b00) begin got = 1'b1; break; end
      end
      Req_Valid_In = 2'b00;
      check("grant_seen", {31'd0, got}, 32'd1);
      if (!got) return;
      g = cyc;
      check("grant", {30'd0, Req_Grant_Out}, {30'd0, eg});
      step();
      check("busy_rise", {31'd0, Busy_Out}, 32'd1);
      got = 1'b0;
      for (int t = 0; t < v.lat + 100; t++) begin
         step();
         if (Done_Out != 2'b00) begin got = 1'b1; break; end
      end
      check("done_seen", {31'd0, got}, 32'd1);
      if (!got) return;
      check("done_latency", cyc - g, v.lat);
      check("done_owner", {30'd0, Done_Out}, {30'd0, eg});
      check("busy_fall", {31'd0, Busy_Out}, 32'd0);
      check("nack", {31'd0, Nack_Out}, {31'd0, v.nack});
      if (v.rw || v.nack) check("rdata", {24'd0, Rdata_Out}, {24'd0, v.rdata});
      check("start_count", n_start - st0, 1);
      check("stop_count", n_stop - sp0, 1);
      if (!v.rw && !v.nack) begin
         check("slave_reg", {24'd0, s_got_reg}, {24'd0, v.rad});
         check("slave_data", {24'd0, s_got_data}, {24'd0, v.wdata});
      end
      if (v.rw && !v.nack) check("master_nack_bit", {31'd0, s_mnack}, 32'd1);
      step();
      check("done_pulse_end", {30'd0, Done_Out}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   g, pd;
      bit   got, saw;
      vec_t rv;
      rst = 1'b1;
      Req_Valid_In = 2'b00; Req_Dev_Addr_In = 14'h0; Req_Rw_In = 2'b00;
      Req_Reg_Addr_In = 16'h0; Req_Wdata_In = 16'h0;
      s_tx_data = 8'h00; s_nack_at = 0;
      //         ri dev    rw    rad    wdata  sdata  nack lat  rdata  nack
      vecs[0] = '{0, 7'h68, 1'b0, 8'h10, 8'hA5, 8'h00, 0, 465, 8'h00, 1'b0};
      vecs[1] = '{1, 7'h68, 1'b1, 8'h00, 8'h00, 8'h3C, 0, 321, 8'h3C, 1'b0};
      vecs[2] = '{0, 7'h50, 1'b0, 8'h10, 8'hA5, 8'h00, 0, 177, 8'h00, 1'b1};
      vecs[3] = '{1, 7'h68, 1'b1, 8'h00, 8'h00, 8'hC3, 0, 321, 8'hC3, 1'b0};
      vecs[4] = '{1, 7'h68, 1'b0, 8'h7E, 8'h81, 8'h00, 0, 465, 8'h00, 1'b0};
      vecs[5] = '{0, 7'h51, 1'b1, 8'h00, 8'h00, 8'hFF, 0, 177, 8'h00, 1'b1};
      vecs[6] = '{0, 7'h68, 1'b0, 8'h42, 8'h99, 8'h00, 1, 321, 8'h00, 1'b1};
      vecs[7] = '{1, 7'h68, 1'b0, 8'h24, 8'h66, 8'h00, 2, 465, 8'h00, 1'b1};

      repeat (3) step();
      check("rst_grant", {30'd0, Req_Grant_Out}, 32'd0);
      check("rst_done", {30'd0, Done_Out}, 32'd0);
      check("rst_rdata", {24'd0, Rdata_Out}, 32'd0);
      check("rst_nack", {31'd0, Nack_Out}, 32'd0);
      check("rst_busy", {31'd0, Busy_Out}, 32'd0);
      check("rst_scl", {31'd0, I2C_SCL}, 32'd1);
      check("rst_sda", {31'd0, w_sda}, 32'd1);
      rst = 1'b0;
      mon_en = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Both requesters held valid from reset release: grants must alternate
      rst = 1'b1;
      Req_Dev_Addr_In = {7'h68, 7'h68}; Req_Rw_In = 2'b11; Req_Valid_In = 2'b11;
      s_tx_data = 8'h96; s_nack_at = 0;
      step();
      rst = 1'b0;
      pd = 0;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int t = 0; t < 50; t++) begin
            step();
            if (Req_Grant_Out != 2'b00) begin got = 1'b1; break; end
         end
         check("arb_grant_seen", {31'd0, got}, 32'd1);
         if (!got) break;
         g = cyc;
         check("arb_grant", {30'd0, Req_Grant_Out}, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k > 0) check("arb_grant_after_done", g - pd, 1);
         got = 1'b0;
         for (int t = 0; t < 500; t++) begin
            step();
            if (Done_Out != 2'b00) begin got = 1'b1; break; end
         end
         check("arb_done_latency", got ? (cyc - g) : 0, 321);
         if (!got) break;
         check("arb_done_owner", {30'd0, Done_Out}, (k % 2 == 0) ? 32'd1 : 32'd2);
         pd = cyc;
      end
      Req_Valid_In = 2'b00;
      repeat (5) step();

      // Reset asserted in the register phase of a write
      Req_Dev_Addr_In[6:0] = 7'h68; Req_Rw_In[0] = 1'b0;
      Req_Reg_Addr_In[7:0] = 8'h22; Req_Wdata_In[7:0] = 8'h33;
      Req_Valid_In = 2'b01;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         step();
         if (Req_Grant_Out != 2'b00) begin got = 1'b1; break; end
      end
      Req_Valid_In = 2'b00;
      check("rr_grant_seen", {31'd0, got}, 32'd1);
      g = cyc;
      while (cyc < g + 1 + 10 * BIT_T + 5) step();
      check("rr_busy_before", {31'd0, Busy_Out}, 32'd1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("rr_scl", {31'd0, I2C_SCL}, 32'd1);
      check("rr_sda", {31'd0, w_sda}, 32'd1);
      check("rr_busy", {31'd0, Busy_Out}, 32'd0);
      saw = (Done_Out != 2'b00);
      repeat (3) begin
         step();
         if (Done_Out != 2'b00) saw = 1'b1;
      end
      rst = 1'b0;
      repeat (20) begin
         step();
         if (Done_Out != 2'b00) saw = 1'b1;
      end
      check("rr_no_done", {31'd0, saw}, 32'd0);
      mon_en = 1'b1;
      rv = '{1, 7'h68, 1'b1, 8'h00, 8'h00, 8'h5A, 0, 321, 8'h5A, 1'b0};
      run_txn(rv);

      repeat (5) step();
      check("protocol_monitor", mon_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_master_sched.md
# i2c_master_sched

Two-requester I2C master controller that arbitrates register-access requests and sequences the full bus transaction (START, device address, register address, data, ACK handling, STOP) toward the team's I2C slave blocks. It sits between on-chip agents and the physical SCL/SDA pins. It owns bit timing, open-drain SDA control and round-robin sharing of the single bus.

## Interface
- CLK_DIV, 25, system-clock cycles per SCL quarter-period (min 2); one bit-time = 4*CLK_DIV cycles
- Clk_In  in  1  system clock, all logic on rising edge
- Reset_In  in  1  reset, asynchronous, active-high
- Req_Valid_In  in  2  request pending, bit i = requester i; held until granted
- Req_Dev_Addr_In  in  14  7-bit device address per requester, [6:0]=req0, [13:7]=req1
- Req_Rw_In  in  2  1 = read, 0 = write, per requester
- Req_Reg_Addr_In  in  16  register address per requester, [7:0]=req0
- Req_Wdata_In  in  16  write data per requester, [7:0]=req0
- Req_Grant_Out  out  2  one-cycle one-hot pulse; request fields latched this cycle
- Done_Out  out  2  one-cycle one-hot pulse to owner at transaction end
- Rdata_Out  out  8  read data, valid with Done_Out, held until next Done
- Nack_Out  out  1  1 = slave NACKed, valid with Done_Out, held until next Done
- Busy_Out  out  1  transaction in progress
- I2C_SCL  out  1  push-pull SCL, 1 when idle
- I2C_SDA  inout  1  open-drain: drives 0 or Z, never 1

## Operation
- Reset values: Req_Grant_Out 0, Done_Out 0, Rdata_Out 0x00, Nack_Out 0, Busy_Out 0, I2C_SCL 1, I2C_SDA Z, last-grant pointer = 1 (req0 wins first tie).
- Arbitration, IDLE only: one valid -> grant it; both valid -> grant the one not granted last; update pointer on grant. Valid during Busy is ignored until IDLE.
- States: IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MNACK, STOP.
- Write path: START-ADDR{addr,0}-ADDR_ACK-REG-REG_ACK-WDATA-WDATA_ACK-STOP-IDLE.
- Read path: START-ADDR{addr,1}-ADDR_ACK-RDATA-MNACK-STOP-IDLE. There is no register phase on reads.
- Bytes go MSB first, 4-bit bit counter 7 down to 0.
- ACK states release SDA and sample it. If SDA is 1, Nack is set and the FSM goes straight to STOP.
- On NACK, Rdata_Out is written as 0x00.
- RDATA shifts sampled bits into an 8-bit register. MNACK releases SDA (master NACK ends the read).
- Done_Out pulses for the granted requester in the IDLE-entry cycle. Rdata_Out and Nack_Out update in the same cycle.
- Asynchronous reset mid-transaction: everything returns to reset values immediately, the bus is released, and no Done pulse is issued.

## Timing
- A quarter tick is generated every CLK_DIV cycles by a free-running divider that restarts on grant.
- Data bits: quarter 0 has SCL 0 and SDA updated. Quarter 1 raises SCL to 1. Quarter 2 keeps SCL 1 and samples SDA at its start. Quarter 3 drops SCL to 0.
- START bit-time: SDA Z with SCL 1 (q0-q1), then SDA 0 with SCL 1 (q2), then SCL 0 (q3).
- STOP bit-time: SDA 0 with SCL 0 (q0), SCL 1 (q1), SDA Z with SCL 1 (q2-q3).
- SDA never changes while SCL is 1, except in START and STOP.
- Grant pulse in cycle G. Busy_Out rises at G+1; START begins at G+1.
- Done_Out is at G+1+N*4*CLK_DIV:
  - write: N=29
  - read: N=20
  - NACK on address: N=11
  - NACK on register: N=20
  - NACK on write data: N=29
- Busy_Out falls in the Done cycle. The earliest next grant is Done+1.

## Test plan
- CLK_DIV=4, req0 writes dev 0x68 reg 0x10 data 0xA5 to slave model (DEVICE_ADDRESS 0x68) -> Grant 01, slave register address 0x10 and data 0xA5; Done 01 at G+465; Nack 0.
- req1 reads dev 0x68, slave S_Data_In 0x3C -> Done 10 at G+321, Rdata_Out 0x3C, Nack 0, SDA released in MNACK.
- req0 writes dev 0x50 (no slave) -> Done 01 at G+177, Nack 1, Rdata 0x00, STOP seen on the bus.
- Both valid at reset release, held after each grant -> grants alternate 01,10,01,10, each only in IDLE; no overlap of Busy.
- Reset_In asserted during REG phase -> within one cycle SCL 1, SDA Z, Busy 0, no Done. A following read of 0x68 completes normally.
- Protocol monitor across all scenarios -> SDA never driven 1, no SDA edge while SCL high except START/STOP, SCL high/low each exactly 2*CLK_DIV cycles.
